pe_gen: RTL and testbench

- Next-generation processing element for the tiled Life array.
- Generalises the two-state Conway PE to "Generations" rule families: a multi-state cell (live, N-2 refractory/dying states, dead), with runtime-loadable birth/survive rule masks and a saturating per-cell live-age counter.
- Drops into the same row/column-select array fabric as a direct replacement for the two-state PE; neighbour status remains one live bit per PE.

---
 rtl/pe_gen.sv | 129 ++++++++++++
 tb/tb_pe_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_gen.sv
// Generations-rule processing element for the tiled Life array.
// Multi-state cell with loadable birth/survive masks and a saturating live-age counter.
//
//   state          | meaning
//   0              | DEAD
//   1              | LIVE (only state reported on status_out)
//   2..N_STATES-1  | DYING, advances one step per PROCESS, then DEAD
module pe_gen #(
    parameter int N_STATES   = 3,
    parameter int STATE_BITS = 2,
    parameter int AGE_BITS   = 8,
    parameter int CMD_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rsel_i,
    input  logic                  csel_i,
    input  logic                  rsel_o,
    input  logic                  csel_o,
    input  logic [CMD_BITS-1:0]   cmd,
    input  logic [STATE_BITS-1:0] state_in,
    input  logic [17:0]           rule_in,
    output logic [STATE_BITS-1:0] state_out,
    output logic [AGE_BITS-1:0]   age_out,
    output logic                  status_out,
    output logic                  active,
    input  logic                  w_i,
    input  logic                  e_i,
    input  logic                  n_i,
    input  logic                  s_i,
    input  logic                  nw_i,
    input  logic                  ne_i,
    input  logic                  sw_i,
    input  logic                  se_i
);

    localparam logic [CMD_BITS-1:0]   CMD_PROCESS = CMD_BITS'(1);
    localparam logic [CMD_BITS-1:0]   CMD_WRITE   = CMD_BITS'(2);
    localparam logic [CMD_BITS-1:0]   CMD_LOAD    = CMD_BITS'(3);
    localparam logic [CMD_BITS-1:0]   CMD_CLEAR   = CMD_BITS'(4);

    localparam logic [STATE_BITS-1:0] ST_DEAD   = '0;
    localparam logic [STATE_BITS-1:0] ST_LIVE   = STATE_BITS'(1);
    localparam logic [STATE_BITS-1:0] ST_DYING0 = (N_STATES > 2) ? STATE_BITS'(2) : ST_DEAD;
    localparam logic [STATE_BITS-1:0] ST_LAST   = STATE_BITS'(N_STATES - 1);
    localparam logic [STATE_BITS:0]   N_ST      = (STATE_BITS + 1)'(N_STATES);
    localparam logic [AGE_BITS-1:0]   AGE_MAX   = '1;

    localparam logic [8:0] BIRTH_RST   = 9'b000001000;
    localparam logic [8:0] SURVIVE_RST = 9'b000001100;

    logic [STATE_BITS-1:0] state_q, state_d;
    logic [AGE_BITS-1:0]   age_q, age_d;
    logic [8:0]            birth_q, birth_d;
    logic [8:0]            survive_q, survive_d;
    logic [3:0]            count;
    logic                  sel_i;
    logic                  sel_o;

    assign sel_i = rsel_i & csel_i;
    assign sel_o = rsel_o & csel_o;

    assign count = 4'(w_i) + 4'(e_i) + 4'(n_i) + 4'(s_i)
                 + 4'(nw_i) + 4'(ne_i) + 4'(sw_i) + 4'(se_i);

    always_comb begin
        state_d   = state_q;
        age_d     = age_q;
        birth_d   = birth_q;
        survive_d = survive_q;
        case (cmd)
            CMD_PROCESS: begin
                if (state_q == ST_DEAD) begin
                    state_d = birth_q[count] ? ST_LIVE : ST_DEAD;
                end else if (state_q == ST_LIVE) begin
                    state_d = survive_q[count] ? ST_LIVE : ST_DYING0;
                end else begin
                    // dying cells ignore neighbours and just count down to DEAD
                    state_d = (state_q < ST_LAST) ? state_q + 1'b1 : ST_DEAD;
                end
                if (state_q == ST_LIVE && state_d == ST_LIVE) begin
                    age_d = (age_q == AGE_MAX) ? age_q : age_q + 1'b1;
                end else begin
                    age_d = '0;
                end
            end
            CMD_WRITE: begin
                if (sel_i) begin
                    state_d = ({1'b0, state_in} < N_ST) ? state_in : ST_DEAD;
                    age_d   = '0;
                end
            end
            CMD_LOAD: begin
                if (sel_i) begin
                    birth_d   = rule_in[8:0];
                    survive_d = rule_in[17:9];
                end
            end
            CMD_CLEAR: begin
                state_d = ST_DEAD;
                age_d   = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_DEAD;
            age_q     <= '0;
            birth_q   <= BIRTH_RST;
            survive_q <= SURVIVE_RST;
        end else begin
            state_q   <= state_d;
            age_q     <= age_d;
            birth_q   <= birth_d;
            survive_q <= survive_d;
        end
    end

    // under reset the real next value is DEAD/0, whatever cmd says
    assign active = rst ? ((state_q != ST_DEAD) || (age_q != '0))
                        : ((state_d != state_q) || (age_d != age_q));

    assign state_out  = sel_o ? state_q : '0;
    assign age_out    = sel_o ? age_q : '0;
    assign status_out = (state_q == ST_LIVE);

endmodule

// File: tb/tb_pe_gen.sv
// Bench for pe_gen: four instances with different parameters share stimulus;
// a per-instance rule model checks every cycle, plus vector table and directed sequences.
module tb_pe_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cmd;
    logic [1:0]  state_in;
    logic [17:0] rule_in;
    logic [7:0]  nb;
    logic [3:0]  rsel_i;
    logic        csel_i, rsel_o, csel_o;

    logic [1:0]  so_w[4];
    logic [7:0]  age_w[4];
    logic        st_w[4];
    logic        act_w[4];
    logic [1:0]  age2, age3;

    assign age_w[2] = {6'b0, age2};
    assign age_w[3] = {6'b0, age3};

    always #5 clk = ~clk;

    pe_gen #(.N_STATES(3), .STATE_BITS(2), .AGE_BITS(8), .CMD_BITS(3)) u0 (
        .clk(clk), .rst(rst), .rsel_i(rsel_i[0]), .csel_i(csel_i), .rsel_o(rsel_o), .csel_o(csel_o),
        .cmd(cmd), .state_in(state_in), .rule_in(rule_in), .state_out(so_w[0]), .age_out(age_w[0]),
        .status_out(st_w[0]), .active(act_w[0]), .w_i(nb[0]), .e_i(nb[1]), .n_i(nb[2]), .s_i(nb[3]),
        .nw_i(nb[4]), .ne_i(nb[5]), .sw_i(nb[6]), .se_i(nb[7]));
    pe_gen #(.N_STATES(3), .STATE_BITS(2), .AGE_BITS(8), .CMD_BITS(3)) u1 (
        .clk(clk), .rst(rst), .rsel_i(rsel_i[1]), .csel_i(csel_i), .rsel_o(rsel_o), .csel_o(csel_o),
        .cmd(cmd), .state_in(state_in), .rule_in(rule_in), .state_out(so_w[1]), .age_out(age_w[1]),
        .status_out(st_w[1]), .active(act_w[1]), .w_i(nb[0]), .e_i(nb[1]), .n_i(nb[2]), .s_i(nb[3]),
        .nw_i(nb[4]), .ne_i(nb[5]), .sw_i(nb[6]), .se_i(nb[7]));
    pe_gen #(.N_STATES(4), .STATE_BITS(2), .AGE_BITS(2), .CMD_BITS(3)) u2 (
        .clk(clk), .rst(rst), .rsel_i(rsel_i[2]), .csel_i(csel_i), .rsel_o(rsel_o), .csel_o(csel_o),
        .cmd(cmd), .state_in(state_in), .rule_in(rule_in), .state_out(so_w[2]), .age_out(age2),
        .status_out(st_w[2]), .active(act_w[2]), .w_i(nb[0]), .e_i(nb[1]), .n_i(nb[2]), .s_i(nb[3]),
        .nw_i(nb[4]), .ne_i(nb[5]), .sw_i(nb[6]), .se_i(nb[7]));
    pe_gen #(.N_STATES(2), .STATE_BITS(2), .AGE_BITS(2), .CMD_BITS(3)) u3 (
        .clk(clk), .rst(rst), .rsel_i(rsel_i[3]), .csel_i(csel_i), .rsel_o(rsel_o), .csel_o(csel_o),
        .cmd(cmd), .state_in(state_in), .rule_in(rule_in), .state_out(so_w[3]), .age_out(age3),
        .status_out(st_w[3]), .active(act_w[3]), .w_i(nb[0]), .e_i(nb[1]), .n_i(nb[2]), .s_i(nb[3]),
        .nw_i(nb[4]), .ne_i(nb[5]), .sw_i(nb[6]), .se_i(nb[7]));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model, one slot per instance
    int         NP[4]   = '{3, 3, 4, 2};
    int         AMAX[4] = '{255, 255, 3, 3};
    int         m_st[4], m_age[4];
    logic [8:0] m_b[4], m_s[4];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_next(input int d, output int ns, output int na,
                              output logic [8:0] b, output logic [8:0] s);
        int cnt;
        cnt = $countones(nb);
        ns = m_st[d]; na = m_age[d]; b = m_b[d]; s = m_s[d];
        if (rst) begin
            ns = 0; na = 0; b = 9'h008; s = 9'h00C;
        end else begin
            case (cmd)
                3'd1: begin
                    if (m_st[d] == 0)      ns = m_b[d][cnt] ? 1 : 0;
                    else if (m_st[d] == 1) ns = m_s[d][cnt] ? 1 : (NP[d] > 2 ? 2 : 0);
                    else                   ns = (m_st[d] < NP[d] - 1) ? m_st[d] + 1 : 0;
                    if (m_st[d] == 1 && ns == 1) na = (m_age[d] < AMAX[d]) ? m_age[d] + 1 : AMAX[d];
                    else na = 0;
                end
                3'd2: if (rsel_i[d] && csel_i) begin
                    ns = (int'(state_in) < NP[d]) ? int'(state_in) : 0;
                    na = 0;
                end
                3'd3: if (rsel_i[d] && csel_i) begin
                    b = rule_in[8:0]; s = rule_in[17:9];
                end
                3'd4: begin ns = 0; na = 0; end
                default: ;
            endcase
        end
    endtask

    // check every instance mid-cycle against the model, then advance one clock
    task automatic cycle();
        int ns[4], na[4];
        logic [8:0] b[4], s[4];
        logic sel_o;
        @(negedge clk);
        sel_o = rsel_o && csel_o;
        for (int d = 0; d < 4; d++) begin
            model_next(d, ns[d], na[d], b[d], s[d]);
            chk($sformatf("model_active[%0d]", d), act_w[d], (ns[d] != m_st[d] || na[d] != m_age[d]) ? 1 : 0);
            chk($sformatf("model_state[%0d]", d), so_w[d], sel_o ? m_st[d] : 0);
            chk($sformatf("model_age[%0d]", d), age_w[d], sel_o ? m_age[d] : 0);
            chk($sformatf("model_status[%0d]", d), st_w[d], (m_st[d] == 1) ? 1 : 0);
        end
        @(posedge clk);
        for (int d = 0; d < 4; d++) begin
            m_st[d] = ns[d]; m_age[d] = na[d]; m_b[d] = b[d]; m_s[d] = s[d];
        end
        #1;
    endtask

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] nb;
        logic [1:0] sin;
        logic       sel;
        int         exp_state;
        int         exp_age;
        int         exp_act;
    } vec_t;

    vec_t tbl[12];
    int   exp_s4[4] = '{2, 3, 0, 0};
    int   exp_a4[4] = '{1, 1, 1, 0};
    int   exp_age[5] = '{1, 2, 3, 3, 3};

    initial begin
        tbl[0]  = '{3'd1, 8'h07, 2'd0, 1'b1, 1, 0, 1};   // birth on 3
        tbl[1]  = '{3'd1, 8'h03, 2'd0, 1'b1, 1, 1, 1};   // survive on 2, age 1
        tbl[2]  = '{3'd1, 8'h0F, 2'd0, 1'b1, 2, 0, 1};   // overcrowded -> dying
        tbl[3]  = '{3'd1, 8'hFF, 2'd0, 1'b1, 0, 0, 1};   // last dying -> dead
        tbl[4]  = '{3'd1, 8'h03, 2'd0, 1'b1, 0, 0, 0};   // dead stays dead
        tbl[5]  = '{3'd2, 8'h00, 2'd1, 1'b1, 1, 0, 1};   // write live
        tbl[6]  = '{3'd0, 8'hFF, 2'd0, 1'b1, 1, 0, 0};   // nop
        tbl[7]  = '{3'd5, 8'hFF, 2'd0, 1'b1, 1, 0, 0};   // reserved cmd
        tbl[8]  = '{3'd1, 8'h0C, 2'd0, 1'b1, 1, 1, 1};
        tbl[9]  = '{3'd4, 8'h00, 2'd0, 1'b0, 0, 0, 1};   // clear ignores select
        tbl[10] = '{3'd2, 8'h00, 2'd2, 1'b1, 2, 0, 1};
        tbl[11] = '{3'd2, 8'h00, 2'd3, 1'b1, 0, 0, 1};   // out of range -> dead

        rst = 1'b1; cmd = 3'd0; state_in = '0; rule_in = '0; nb = '0;
        rsel_i = 4'hF; csel_i = 1'b1; rsel_o = 1'b1; csel_o = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            m_st[d] = 0; m_age[d] = 0; m_b[d] = 9'h008; m_s[d] = 9'h00C;
        end
        chk("reset_state", so_w[0], 0);
        chk("reset_age", age_w[0], 0);
        chk("reset_status", st_w[0], 0);
        cycle();

        // vector table on the default N_STATES=3 instance
        for (int i = 0; i < 12; i++) begin
            cmd = tbl[i].cmd; nb = tbl[i].nb; state_in = tbl[i].sin; rsel_i = {4{tbl[i].sel}};
            #2;
            chk($sformatf("tbl%0d_active", i), act_w[0], tbl[i].exp_act);
            cycle();
            chk($sformatf("tbl%0d_state", i), so_w[0], tbl[i].exp_state);
            chk($sformatf("tbl%0d_age", i), age_w[0], tbl[i].exp_age);
        end

        // four-state dying chain, and two-state live->dead
        rsel_i = 4'hF; cmd = 3'd2; state_in = 2'd1;
        cycle();
        cmd = 3'd1; nb = 8'h01;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("ns4_active%0d", i), act_w[2], exp_a4[i]);
            cycle();
            chk($sformatf("ns4_state%0d", i), so_w[2], exp_s4[i]);
            chk($sformatf("ns4_status%0d", i), st_w[2], 0);
            if (i == 0) chk("ns2_live_to_dead", so_w[3], 0);
        end

        // age saturation with AGE_BITS=2
        cmd = 3'd2; state_in = 2'd1;
        cycle();
        cmd = 3'd1; nb = 8'h03;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("age_sat%0d", i), age_w[2], exp_age[i]);
            chk($sformatf("age_sat_live%0d", i), so_w[2], 1);
        end
        cmd = 3'd4;
        cycle();
        chk("clear_state", so_w[2], 0);
        chk("clear_age", age_w[2], 0);

        // B6/S2 load on u0 only; u1 keeps B3/S23
        rsel_i = 4'b0001; cmd = 3'd3; rule_in = {9'b000000100, 9'b001000000};
        #2;
        chk("load_active", act_w[0], 0);
        cycle();
        cmd = 3'd1; nb = 8'h3F;
        cycle();
        chk("b6_born", so_w[0], 1);
        chk("b3_unsel_dead", so_w[1], 0);
        nb = 8'h07;
        cycle();
        chk("s2_dies", so_w[0], 2);
        chk("b3_unsel_born", so_w[1], 1);

        // write clamping and unselected write
        cmd = 3'd2; state_in = 2'd3; rsel_i = 4'b0001;
        cycle();
        chk("write_clamp", so_w[0], 0);
        state_in = 2'd2; rsel_i = 4'b0000;
        #2;
        chk("write_unsel_active", act_w[0], 0);
        cycle();
        chk("write_unsel_state", so_w[0], 0);

        // read and write same cycle shows the old value
        state_in = 2'd1; rsel_i = 4'b0001;
        #2;
        chk("rw_pre_value", so_w[0], 0);
        cycle();
        chk("rw_post_value", so_w[0], 1);

        // mid-run reset restores Conway rules
        cmd = 3'd1; nb = 8'h07; rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_state", so_w[0], 0);
        chk("midrst_age", age_w[0], 0);
        nb = 8'h03;
        cycle();
        chk("midrst_b2_dead", so_w[0], 0);
        nb = 8'h07;
        cycle();
        chk("midrst_b3_born", so_w[0], 1);

        // B0: an isolated dead cell is born
        cmd = 3'd4;
        cycle();
        cmd = 3'd3; rsel_i = 4'b0001; rule_in = {9'h00C, 9'h001};
        cycle();
        cmd = 3'd1; nb = 8'h00;
        cycle();
        chk("b0_born", so_w[0], 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cmd      = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            nb       = 8'($urandom);
            state_in = 2'($urandom);
            rule_in  = 18'($urandom);
            rsel_i   = 4'($urandom);
            csel_i   = ($urandom_range(0, 3) != 0);
            rsel_o   = ($urandom_range(0, 3) != 0);
            csel_o   = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
